ctrl_pipe: RTL and testbench

Pipelined control unit for the five-stage RV32 core: decodes the ID-stage opcode, carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, detects load-use hazards and generates EX-stage forwarding selects. It replaces the purely combinational decoder with the NoOp input. Hazard stalls, branch flushes and external holds are now resolved inside the block. An optional jump extension is also added.

---
 rtl/ctrl_pipe.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID-stage decoder plus ID/EX, EX/MEM and MEM/WB control registers,
// with load-use hazard detection and EX-stage forwarding selects.
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter bit EXT_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        opcode_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic [1:0]        ex_aluop_o,
    output logic              ex_alusrc_o,
    output logic              ex_branch_o,
    output logic              ex_jump_o,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              mem_memread_o,
    output logic              mem_memwrite_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic              wb_link_o,
    output logic [REG_AW-1:0] wb_rd_o
);

    // ctl bits: 9 regwrite, 8 memtoreg, 7 memread, 6 memwrite,
    // 5 branch, 4 jump, 3 link, 2 alusrc, 1:0 aluop
    logic [9:0]        w_ctl;
    logic              w_valid;
    logic              w_use1;
    logic              w_use2;
    logic              w_hazard;
    logic              w_bubble;

    logic [9:0]        r_ide_ctl;
    logic [REG_AW-1:0] r_ide_rs1;
    logic [REG_AW-1:0] r_ide_rs2;
    logic [REG_AW-1:0] r_ide_rd;

    logic              r_exm_regwrite;
    logic              r_exm_memtoreg;
    logic              r_exm_memread;
    logic              r_exm_memwrite;
    logic              r_exm_link;
    logic [REG_AW-1:0] r_exm_rd;

    logic              r_mwb_regwrite;
    logic              r_mwb_memtoreg;
    logic              r_mwb_link;
    logic [REG_AW-1:0] r_mwb_rd;

    // Decode the ID opcode and record which source registers it reads.
    always_comb begin
        w_ctl   = '0;
        w_valid = 1'b0;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        case (opcode_i)
            7'b0000011: begin
                w_ctl   = 10'b1110000100;
                w_valid = 1'b1;
                w_use1  = 1'b1;
            end
            7'b0100011: begin
                w_ctl   = 10'b0001000100;
                w_valid = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            7'b1100011: begin
                w_ctl   = 10'b0000100001;
                w_valid = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            7'b0110011: begin
                w_ctl   = 10'b1000000010;
                w_valid = 1'b1;
                w_use1  = 1'b1;
                w_use2  = 1'b1;
            end
            7'b0010011: begin
                w_ctl   = 10'b1000000111;
                w_valid = 1'b1;
                w_use1  = 1'b1;
            end
            7'b1101111: begin
                if (EXT_EN) begin
                    w_ctl   = 10'b1000011100;
                    w_valid = 1'b1;
                end
            end
            7'b1100111: begin
                if (EXT_EN) begin
                    w_ctl   = 10'b1000011100;
                    w_valid = 1'b1;
                    w_use1  = 1'b1;
                end
            end
            default: begin
                w_ctl   = '0;
                w_valid = 1'b0;
            end
        endcase
    end

    assign w_hazard = r_ide_ctl[7] && (r_ide_rd != '0) &&
                      ((w_use1 && (r_ide_rd == rs1_i)) ||
                       (w_use2 && (r_ide_rd == rs2_i)));
    assign stall_o  = w_hazard && !flush_i && !hold_i;
    assign w_bubble = flush_i || stall_o || !w_valid;

    // ID/EX register: bubble on flush, stall or undefined opcode.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ide_ctl <= '0;
            r_ide_rs1 <= '0;
            r_ide_rs2 <= '0;
            r_ide_rd  <= '0;
        end else if (!hold_i) begin
            if (w_bubble) begin
                r_ide_ctl <= '0;
                r_ide_rs1 <= '0;
                r_ide_rs2 <= '0;
                r_ide_rd  <= '0;
            end else begin
                r_ide_ctl <= w_ctl;
                r_ide_rs1 <= rs1_i;
                r_ide_rs2 <= rs2_i;
                r_ide_rd  <= rd_i;
            end
        end
    end

    // EX/MEM and MEM/WB registers advance unless held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_exm_regwrite <= 1'b0;
            r_exm_memtoreg <= 1'b0;
            r_exm_memread  <= 1'b0;
            r_exm_memwrite <= 1'b0;
            r_exm_link     <= 1'b0;
            r_exm_rd       <= '0;
            r_mwb_regwrite <= 1'b0;
            r_mwb_memtoreg <= 1'b0;
            r_mwb_link     <= 1'b0;
            r_mwb_rd       <= '0;
        end else if (!hold_i) begin
            r_exm_regwrite <= r_ide_ctl[9];
            r_exm_memtoreg <= r_ide_ctl[8];
            r_exm_memread  <= r_ide_ctl[7];
            r_exm_memwrite <= r_ide_ctl[6];
            r_exm_link     <= r_ide_ctl[3];
            r_exm_rd       <= r_ide_rd;
            r_mwb_regwrite <= r_exm_regwrite;
            r_mwb_memtoreg <= r_exm_memtoreg;
            r_mwb_link     <= r_exm_link;
            r_mwb_rd       <= r_exm_rd;
        end
    end

    // Forwarding selects; EX/MEM wins over MEM/WB, x0 never forwards.
    always_comb begin
        forward_a_o = 2'b00;
        forward_b_o = 2'b00;
        if (r_exm_regwrite && r_exm_rd != '0 && r_exm_rd == r_ide_rs1)
            forward_a_o = 2'b10;
        else if (r_mwb_regwrite && r_mwb_rd != '0 && r_mwb_rd == r_ide_rs1)
            forward_a_o = 2'b01;
        if (r_exm_regwrite && r_exm_rd != '0 && r_exm_rd == r_ide_rs2)
            forward_b_o = 2'b10;
        else if (r_mwb_regwrite && r_mwb_rd != '0 && r_mwb_rd == r_ide_rs2)
            forward_b_o = 2'b01;
    end

    assign ex_aluop_o     = r_ide_ctl[1:0];
    assign ex_alusrc_o    = r_ide_ctl[2];
    assign ex_branch_o    = r_ide_ctl[5];
    assign ex_jump_o      = r_ide_ctl[4];
    assign mem_memread_o  = r_exm_memread;
    assign mem_memwrite_o = r_exm_memwrite;
    assign wb_regwrite_o  = r_mwb_regwrite;
    assign wb_memtoreg_o  = r_mwb_memtoreg;
    assign wb_link_o      = r_mwb_link;
    assign wb_rd_o        = r_mwb_rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, load-use, forwarding, flush,
// jump extension on/off and external hold.
module tb_ctrl_pipe;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] NOP = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic       flush, hold;

    logic       stall1, alusrc1, branch1, jump1;
    logic [1:0] aluop1, fa1, fb1;
    logic       mrd1, mwr1, rw1, m2r1, link1;
    logic [4:0] wrd1;
    logic       stall0, alusrc0, branch0, jump0;
    logic [1:0] aluop0, fa0, fb0;
    logic       mrd0, mwr0, rw0, m2r0, link0;
    logic [4:0] wrd0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.REG_AW(5), .EXT_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .flush_i(flush), .hold_i(hold), .stall_o(stall1),
        .ex_aluop_o(aluop1), .ex_alusrc_o(alusrc1),
        .ex_branch_o(branch1), .ex_jump_o(jump1),
        .forward_a_o(fa1), .forward_b_o(fb1),
        .mem_memread_o(mrd1), .mem_memwrite_o(mwr1),
        .wb_regwrite_o(rw1), .wb_memtoreg_o(m2r1),
        .wb_link_o(link1), .wb_rd_o(wrd1)
    );

    ctrl_pipe #(.REG_AW(5), .EXT_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .flush_i(flush), .hold_i(hold), .stall_o(stall0),
        .ex_aluop_o(aluop0), .ex_alusrc_o(alusrc0),
        .ex_branch_o(branch0), .ex_jump_o(jump0),
        .forward_a_o(fa0), .forward_b_o(fb0),
        .mem_memread_o(mrd0), .mem_memwrite_o(mwr0),
        .wb_regwrite_o(rw0), .wb_memtoreg_o(m2r0),
        .wb_link_o(link0), .wb_rd_o(wrd0)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id(input logic [6:0] op, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d);
        opcode = op;
        rs1    = a;
        rs2    = b;
        rd     = d;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        id(NOP, 0, 0, 0);
        #3;
        chk("rst_stall", {7'd0, stall1}, 8'd0);
        chk("rst_ex", {2'd0, aluop1, alusrc1, branch1, jump1, mrd1}, 8'd0);
        chk("rst_fwd", {4'd0, fa1, fb1}, 8'd0);
        chk("rst_wb", {rw1, m2r1, link1, wrd1}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // reset mid-stream with lw in MEM
        id(IMM, 1, 0, 3);
        step();
        id(LW, 3, 0, 9);
        step();
        chk("imm_lw_fa", {6'd0, fa1}, 8'h2);
        id(RT, 3, 3, 4);
        step();
        chk("mid_mrd", {7'd0, mrd1}, 8'd1);
        chk("mid_wbrd", {3'd0, wrd1}, 8'd3);
        chk("mid_fwd", {4'd0, fa1, fb1}, 8'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mrd", {7'd0, mrd1}, 8'd0);
        chk("arst_wbrd", {3'd0, wrd1}, 8'd0);
        chk("arst_fwd", {4'd0, fa1, fb1}, 8'd0);
        chk("arst_ex", {6'd0, aluop1}, 8'd0);
        #1 rst_n = 1'b1;
        id(NOP, 0, 0, 0);
        step();

        // load-use: lw x5 ; add x6,x5,x7
        id(LW, 1, 0, 5);
        step();
        chk("lw_ex", {5'd0, alusrc1, aluop1}, 8'h4);
        id(RT, 5, 7, 6);
        #1;
        chk("lu_stall", {7'd0, stall1}, 8'd1);
        step();
        chk("lu_stall_drop", {7'd0, stall1}, 8'd0);
        chk("lu_bubble", {5'd0, alusrc1, aluop1}, 8'd0);
        chk("lu_mrd", {7'd0, mrd1}, 8'd1);
        step();
        chk("lu_add_ex", {5'd0, alusrc1, aluop1}, 8'h2);
        chk("lu_fwd", {4'd0, fa1, fb1}, 8'h4);
        chk("lu_wb", {rw1, m2r1, link1, wrd1}, {3'b110, 5'd5});
        id(NOP, 0, 0, 0);
        step();
        step();

        // double forward, distance 1
        id(RT, 2, 3, 1);
        step();
        id(RT, 1, 1, 2);
        step();
        chk("fwd_d1", {4'd0, fa1, fb1}, 8'hA);
        // distance 2
        id(RT, 2, 3, 1);
        step();
        id(IMM, 0, 0, 7);
        step();
        id(RT, 1, 1, 2);
        step();
        chk("fwd_d2", {4'd0, fa1, fb1}, 8'h5);
        // destination x0
        id(RT, 2, 3, 0);
        step();
        id(RT, 0, 0, 2);
        step();
        chk("fwd_x0", {4'd0, fa1, fb1}, 8'h0);
        id(NOP, 0, 0, 0);
        step();
        step();

        // flush beats load-use hazard
        id(LW, 1, 0, 5);
        step();
        id(BEQ, 5, 6, 0);
        flush = 1'b1;
        #1;
        chk("fl_stall", {7'd0, stall1}, 8'd0);
        step();
        flush = 1'b0;
        chk("fl_branch", {7'd0, branch1}, 8'd0);
        chk("fl_aluop", {6'd0, aluop1}, 8'd0);
        chk("fl_mrd", {7'd0, mrd1}, 8'd1);
        id(NOP, 0, 0, 0);
        step();
        step();

        // jump extension on (dut1) and off (dut0)
        id(JAL, 3, 0, 1);
        step();
        chk("jal_ex1", {5'd0, jump1, alusrc1, 1'b0}, 8'h6);
        chk("jal_ex0", {5'd0, jump0, alusrc0, 1'b0}, 8'h0);
        id(NOP, 0, 0, 0);
        step();
        chk("jal_mem0", {6'd0, mrd0, mwr0}, 8'h0);
        step();
        chk("jal_wb1", {rw1, m2r1, link1, wrd1}, {3'b101, 5'd1});
        chk("jal_wb0", {rw0, m2r0, link0, wrd0}, 8'h0);
        step();

        // hold with lw/add in flight
        id(IMM, 0, 0, 3);
        step();
        id(LW, 3, 0, 5);
        step();
        id(RT, 5, 7, 6);
        hold = 1'b1;
        #1;
        chk("hd_stall0", {7'd0, stall1}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hd_stall", {7'd0, stall1}, 8'd0);
            chk("hd_ex", {5'd0, alusrc1, aluop1}, 8'h4);
            chk("hd_fa", {6'd0, fa1}, 8'h2);
            chk("hd_wb", {rw1, m2r1, link1, wrd1}, 8'h0);
        end
        hold = 1'b0;
        #1;
        chk("hd_rel_stall", {7'd0, stall1}, 8'd1);
        step();
        chk("hd_bubble", {5'd0, alusrc1, aluop1}, 8'd0);
        chk("hd_stall_off", {7'd0, stall1}, 8'd0);
        chk("hd_mrd", {7'd0, mrd1}, 8'd1);
        step();
        chk("hd_add_fwd", {4'd0, fa1, fb1}, 8'h4);
        chk("hd_add_ex", {6'd0, aluop1}, 8'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
